// File: rtl/fp_pkg.sv
// Shared definitions for the fp_multiplier issue stage and the multiplier it drives.
package fp_pkg;

  // IEEE-754 single-precision field widths.
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MANT_W;

  // Latency contract with fp_multiplier: start is held for START_CYC_DEF cycles,
  // then the result is valid MUL_LAT_DEF cycles after start falls.
  localparam int START_CYC_DEF = 3;
  localparam int MUL_LAT_DEF   = 26;

  // Issue-stage sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // One buffered operand pair; a occupies the upper half of the packed word.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } pair_t;

  // Counter width able to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fp_pair_fifo.sv
// Operand-pair FIFO: DEPTH entries (power of two), pointers wrap modulo DEPTH.
module fp_pair_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2 * FP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  // Never write into a full FIFO or read from an empty one, whatever the caller does.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level == (PTR_W + 1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rptr];

  // Storage write port.
  // NOTE: the data array has no reset; occupancy is tracked by level, so stale
  // entries are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; push+pop in one cycle leaves level unchanged.
  // NOTE: sequential state uses non-blocking assignment so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + (PTR_W + 1)'(1);
      else if (do_pop && !do_push) level <= level - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/fp_mult_issue.sv
// Issue/collect stage for fp_multiplier: buffers operand pairs, sequences the
// multiplier start/latency protocol and presents products on a valid/ready stream.
module fp_mult_issue
  import fp_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter int         START_CYC = START_CYC_DEF,
  parameter int         MUL_LAT   = MUL_LAT_DEF,
  parameter logic       MUL_MODE  = 1'b1,
  parameter logic [7:0] MUL_CFG   = 8'h81
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FP_W-1:0]        in_a,
  input  logic [FP_W-1:0]        in_b,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [FP_W-1:0]        out_result,
  output logic                   out_of,
  output logic                   out_uf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FP_W-1:0]        mul_a,
  output logic [FP_W-1:0]        mul_b,
  output logic                   mul_mode,
  output logic [7:0]             mul_cfg,
  output logic                   mul_start,
  input  logic [FP_W-1:0]        mul_result,
  input  logic                   mul_of,
  input  logic                   mul_uf,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CNT_MAX = (MUL_LAT > START_CYC) ? MUL_LAT : START_CYC;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(MUL_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             start_nxt;
  logic             pop;
  logic             capture;
  logic             out_clear;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  pair_t            head;

  assign push     = in_valid && in_ready;
  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign mul_mode = MUL_MODE;
  assign mul_cfg  = MUL_CFG;

  fp_pair_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * FP_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Next-state, counter and datapath-control decode.
  // NOTE: every signal written here gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_nxt = mul_start;
    pop       = 1'b0;
    capture   = 1'b0;
    out_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          start_nxt = 1'b1;
          cnt_nxt   = START_LOAD;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (cnt == '0) begin
          start_nxt = 1'b0;
          cnt_nxt   = RUN_LOAD;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RUN: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_clear = 1'b1;
          // Chain straight into the next operation on the handshake edge.
          if (!fifo_empty) begin
            pop       = 1'b1;
            start_nxt = 1'b1;
            cnt_nxt   = START_LOAD;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, cycle counter and multiplier start register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mul_start <= start_nxt;
    end
  end

  // Operand registers: loaded on pop, stable until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (pop) begin
      mul_a <= head.a;
      mul_b <= head.b;
    end
  end

  // Output register: captures the product once per operation, holds it under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_of     <= 1'b0;
      out_uf     <= 1'b0;
      out_valid  <= 1'b0;
    end else if (capture) begin
      out_result <= mul_result;
      out_of     <= mul_of;
      out_uf     <= mul_uf;
      out_valid  <= 1'b1;
    end else if (out_clear) begin
      out_valid <= 1'b0;
    end
  end

endmodule
